mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the EX stage; replaces the single-cycle mul path (ALUControl 3'b101) with a parametrised, multi-cycle engine.
- Decodes its own Funct field and owns the architectural HI/LO registers.
- Supports signed and unsigned MULT/DIV plus MTHI/MTLO.
- Drives Busy to the hazard unit so the pipeline stalls while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand width W; HI and LO are each W bits.
- Funct_width, 6, width of the instruction funct field.
- CNT_WIDTH, 6, iteration-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous active-low reset.
- Start  input  1  EX-stage instruction is an MDU op; sampled only when Busy=0.
- Funct  input  Funct_width  op select.
- SrcA  input  DATA_WIDTH  multiplicand/dividend; MTHI/MTLO data.
- SrcB  input  DATA_WIDTH  multiplier/divisor.
- Flush  input  1  abort the in-flight op.
- Busy  output  1  op in progress; stall request.
- Done  output  1  one-cycle pulse when HI/LO are updated by MULT/DIV.
- DivZero  output  1  one-cycle pulse alongside Done when the divisor was 0.
- HI  output  DATA_WIDTH  HI register (MFHI source).
- LO  output  DATA_WIDTH  LO register (MFLO source).

Behaviour:
- Reset (RST=0, asynchronous): state IDLE; Busy=0, Done=0, DivZero=0, HI=0, LO=0; counter and datapath registers cleared.
- Funct encodings:
  - MULT 6'b011000, MULTU 6'b011001, DIV 6'b011010, DIVU 6'b011011, MTHI 6'b010001, MTLO 6'b010011.
  - Any other Funct with Start=1: ignored, no state change.
- States: IDLE, MUL, DIV, FIX.
- IDLE, Start=1:
  - MTHI/MTLO: HI (or LO) <= SrcA at that edge; stay IDLE; Busy stays 0; no Done.
  - MULT(U)/DIV(U): latch operand magnitudes (signed ops take two's-complement absolute value), latch sign flags and the op; counter <= 0; go to MUL/DIV. Busy=1 from the next cycle.
- MUL: radix-2 shift-add on a 2W-bit accumulator, one multiplier bit per cycle; W cycles, then FIX.
- DIV: restoring division, one quotient bit per cycle; W cycles, then FIX.
- FIX, one cycle:
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the operand signs differ. Remainder takes the dividend's sign.
  - Write {HI,LO} for multiply, or HI=remainder, LO=quotient for divide.
  - Go to IDLE with Done=1 registered for that following cycle.
- Latency: Start in cycle 0 -> Busy=1 in cycles 1..W+1 -> Busy=0, Done=1, HI/LO new in cycle W+2.
- Busy=1 is decoded from the state register; Done and DivZero are registered pulses, exactly 1 cycle wide.
- Start while Busy=1: ignored; the pipeline is stalled and re-presents the instruction, which must not restart the engine.
- Divisor zero: no iteration shortcut. Result is forced in FIX: HI=SrcA as latched (original dividend), LO=all ones; DivZero=1 with Done.
- Signed overflow (DIV of -2^(W-1) by -1): LO=-2^(W-1) (W-bit wrap), HI=0; no flag.
- Flush=1:
  - In any non-IDLE state: return to IDLE next edge; HI/LO unchanged; no Done.
  - Flush has priority over FIX completion.
  - Flush in IDLE simultaneous with Start: Start ignored.
- HI/LO are only written in FIX or by MTHI/MTLO; reads are combinational from the registers.

Test Plan:
- Reset: assert RST=0 mid-MUL (cycle 10) -> Busy, HI, LO, Done all 0 immediately, before the next clock edge.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy cycles 1..33, Done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -7 x 3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> HI=100, LO=0xFFFFFFFF, DivZero=1 with Done. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234 then MULT 2x3 with Start re-asserted during Busy -> single Done at cycle W+2, HI=0, LO=6. Flush at cycle 5 of a DIV -> no Done, HI/LO keep prior values.
- Start with Funct=6'b100000 (add) -> Busy stays 0, HI/LO unchanged. Run DATA_WIDTH=8 build: MULTU 0xFF x 0x02 -> HI=0x01, LO=0xFE, Done in cycle 10.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider owning HI/LO, with stall and flush control
module mul_div_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int Funct_width = 6,
   parameter int CNT_WIDTH   = 6
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   Start,
   input  logic [Funct_width-1:0] Funct,
   input  logic [DATA_WIDTH-1:0]  SrcA,
   input  logic [DATA_WIDTH-1:0]  SrcB,
   input  logic                   Flush,
   output logic                   Busy,
   output logic                   Done,
   output logic                   DivZero,
   output logic [DATA_WIDTH-1:0]  HI,
   output logic [DATA_WIDTH-1:0]  LO
);
   localparam int W = DATA_WIDTH;
   localparam logic [Funct_width-1:0] F_MULT  = Funct_width'(6'b011000);
   localparam logic [Funct_width-1:0] F_MULTU = Funct_width'(6'b011001);
   localparam logic [Funct_width-1:0] F_DIV   = Funct_width'(6'b011010);
   localparam logic [Funct_width-1:0] F_DIVU  = Funct_width'(6'b011011);
   localparam logic [Funct_width-1:0] F_MTHI  = Funct_width'(6'b010001);
   localparam logic [Funct_width-1:0] F_MTLO  = Funct_width'(6'b010011);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic [2*W-1:0]       acc, opb, prod;
   logic [W-1:0]         mplier, srca, a_abs, b_abs, quo, rem;
   logic [W:0]           shifted, diff;
   logic                 sa, sb, bzero, op_mul;
   logic                 is_mul, is_div, a_neg, b_neg, ge, last;

   assign is_mul = (Funct == F_MULT) || (Funct == F_MULTU);
   assign is_div = (Funct == F_DIV) || (Funct == F_DIVU);
   assign a_neg  = ((Funct == F_MULT) || (Funct == F_DIV)) && SrcA[W-1];
   assign b_neg  = ((Funct == F_MULT) || (Funct == F_DIV)) && SrcB[W-1];
   assign a_abs  = a_neg ? -SrcA : SrcA;
   assign b_abs  = b_neg ? -SrcB : SrcB;
   assign last   = cnt == CNT_WIDTH'(W - 1);
   // division keeps remainder in acc's upper half and the shifting dividend/quotient in the lower half
   assign shifted = {acc[2*W-1:W], acc[W-1]};
   assign diff    = shifted - {1'b0, opb[W-1:0]};
   assign ge      = shifted >= {1'b0, opb[W-1:0]};
   assign prod    = (sa ^ sb) ? -acc : acc;
   assign quo     = (sa ^ sb) ? -acc[W-1:0] : acc[W-1:0];
   assign rem     = sa ? -acc[2*W-1:W] : acc[2*W-1:W];
   assign Busy    = state != IDLE;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         opb     <= '0;
         mplier  <= '0;
         srca    <= '0;
         sa      <= 1'b0;
         sb      <= 1'b0;
         bzero   <= 1'b0;
         op_mul  <= 1'b0;
         HI      <= '0;
         LO      <= '0;
         Done    <= 1'b0;
         DivZero <= 1'b0;
      end else begin
         Done    <= 1'b0;
         DivZero <= 1'b0;
         if (Flush && state != IDLE) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (Start && !Flush) begin
                  if (Funct == F_MTHI) HI <= SrcA;
                  else if (Funct == F_MTLO) LO <= SrcA;
                  else if (is_mul || is_div) begin
                     state  <= is_mul ? MUL : DIV;
                     cnt    <= '0;
                     sa     <= a_neg;
                     sb     <= b_neg;
                     srca   <= SrcA;
                     bzero  <= SrcB == '0;
                     op_mul <= is_mul;
                     acc    <= is_mul ? '0 : {{W{1'b0}}, a_abs};
                     opb    <= {{W{1'b0}}, is_mul ? a_abs : b_abs};
                     mplier <= b_abs;
                  end
               end
               MUL: begin
                  acc    <= acc + (mplier[0] ? opb : '0);
                  opb    <= opb << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + 1'b1;
                  state  <= last ? FIX : MUL;
               end
               DIV: begin
                  acc   <= {ge ? diff[W-1:0] : shifted[W-1:0], acc[W-2:0], ge};
                  cnt   <= cnt + 1'b1;
                  state <= last ? FIX : DIV;
               end
               FIX: begin
                  state   <= IDLE;
                  Done    <= 1'b1;
                  DivZero <= !op_mul && bzero;
                  if (op_mul) {HI, LO} <= prod;
                  else if (bzero) {HI, LO} <= {srca, {W{1'b1}}};
                  else {HI, LO} <= {rem, quo};
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random MULT/DIV/MTHI/MTLO checks against an arithmetic reference model
module tb_mul_div_unit;
   localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
   localparam logic [5:0] MTHI = 6'b010001, MTLO = 6'b010011;

   logic        CLK = 1'b0, RST = 1'b0, Start = 1'b0, Flush = 1'b0;
   logic [5:0]  Funct = '0;
   logic [31:0] SrcA = '0, SrcB = '0, HI, LO;
   logic        Busy, Done, DivZero;
   logic        s8 = 1'b0, busy8, done8, dz8;
   logic [5:0]  f8 = '0;
   logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
   logic [63:0] hl = '0;
   int          total = 0, passed = 0;

   always #5 CLK = ~CLK;

   mul_div_unit dut (.CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct), .SrcA(SrcA), .SrcB(SrcB),
                     .Flush(Flush), .Busy(Busy), .Done(Done), .DivZero(DivZero), .HI(HI), .LO(LO));

   mul_div_unit #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut8 (.CLK(CLK), .RST(RST), .Start(s8), .Funct(f8),
                     .SrcA(a8), .SrcB(b8), .Flush(1'b0), .Busy(busy8), .Done(done8), .DivZero(dz8),
                     .HI(hi8), .LO(lo8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic logic [64:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (f == MULTU) return {1'b0, 64'({32'b0, a} * {32'b0, b})};
      if (f == MULT) return {1'b0, 64'(sa * sb)};
      if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
      if (f == DIVU) return {1'b0, a % b, a / b};
      return {1'b0, 32'(sa % sb), 32'(sa / sb)};
   endfunction

   task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit again);
      logic [64:0] e;
      int nb, early;
      e = model(f, a, b);
      nb = 0;
      early = 0;
      @(negedge CLK);
      Start = 1'b1; Funct = f; SrcA = a; SrcB = b;
      for (int c = 1; c <= 33; c++) begin
         @(negedge CLK);
         Start = again && c < 33;
         nb += int'(Busy);
         early += int'(Done);
      end
      @(negedge CLK);
      chk({tag, "_busy"}, 64'({nb, early}), {32'd33, 32'd0});
      chk({tag, "_done"}, {61'b0, Busy, Done, DivZero}, {61'b0, 1'b0, 1'b1, e[64]});
      chk({tag, "_hilo"}, {HI, LO}, e[63:0]);
      hl = e[63:0];
      @(negedge CLK);
      chk({tag, "_pulse"}, {62'b0, Done, DivZero}, 64'b0);
   endtask

   task automatic mt(input logic [5:0] f, input logic [31:0] v);
      @(negedge CLK);
      Start = 1'b1; Funct = f; SrcA = v;
      @(negedge CLK);
      Start = 1'b0;
      if (f == MTHI) hl[63:32] = v; else hl[31:0] = v;
      chk("mt", {Busy, Done, 30'b0, HI, LO}, {2'b00, 30'b0, hl});
   endtask

   initial begin
      logic [5:0]  fs [4] = '{MULT, MULTU, DIV, DIVU};
      logic [31:0] a, b;
      int nd, nb;
      repeat (2) @(negedge CLK);
      chk("reset", {Busy, Done, DivZero, 29'b0, HI, LO}, 64'b0);
      RST = 1'b1;
      mt(MTHI, 32'h1234);
      do_op("mult_restart", MULT, 32'd2, 32'd3, 1'b1);
      do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      chk("multu_max_val", hl, 64'hFFFF_FFFE_0000_0001);
      do_op("mult_neg", MULT, -32'sd7, 32'd3, 1'b0);
      chk("mult_neg_val", hl, 64'hFFFF_FFFF_FFFF_FFEB);
      do_op("div_neg", DIV, -32'sd7, 32'd2, 1'b0);
      chk("div_neg_val", hl, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op("divu_zero", DIVU, 32'd100, 32'd0, 1'b0);
      chk("divu_zero_val", hl, {32'd100, 32'hFFFF_FFFF});
      do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      chk("div_ovf_val", hl, {32'd0, 32'h8000_0000});
      // unrecognised funct must leave everything untouched
      @(negedge CLK);
      Start = 1'b1; Funct = 6'b100000; SrcA = 32'hDEAD; SrcB = 32'h1;
      @(negedge CLK);
      Start = 1'b0;
      @(negedge CLK);
      chk("illegal", {Busy, Done, 30'b0, HI, LO}, {2'b00, 30'b0, hl});
      mt(MTHI, 32'hAAAA);
      mt(MTLO, 32'h5555);
      @(negedge CLK);
      Start = 1'b1; Funct = DIV; SrcA = 32'd1000; SrcB = 32'd7;
      nd = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         Start = 1'b0;
         Flush = c == 5;
         nd += int'(Done) + int'(DivZero);
         if (c == 6) chk("flush_idle", {63'b0, Busy}, 64'b0);
      end
      chk("flush_nodone", 64'(nd), 64'd0);
      chk("flush_hilo", {HI, LO}, hl);
      for (int i = 0; i < 16; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom_range(0, 1) == 1) ? $urandom_range(1, 9) : $urandom;
         if (i % 5 == 0) a = -$urandom_range(1, 50);
         do_op("rand", fs[$urandom_range(0, 3)], a, b, i[0]);
      end
      mt(MTHI, 32'h0F0F);
      @(negedge CLK);
      Start = 1'b1; Funct = MULT; SrcA = 32'd5; SrcB = 32'd9;
      repeat (10) @(negedge CLK);
      Start = 1'b0;
      chk("pre_reset_busy", {63'b0, Busy}, 64'd1);
      RST = 1'b0;
      #1;
      chk("async_reset", {Busy, Done, 30'b0, HI, LO}, 64'b0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      s8 = 1'b1; f8 = MULTU; a8 = 8'hFF; b8 = 8'h02;
      nb = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge CLK);
         s8 = 1'b0;
         nb += int'(busy8);
      end
      @(negedge CLK);
      chk("w8_busy", 64'(nb), 64'd9);
      chk("w8_done", {62'b0, busy8, done8}, 64'd1);
      chk("w8_hilo", {48'b0, hi8, lo8}, 64'h01FE);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
